// File: rtl/adc_frontend_nch.sv
// Multi-channel ADC front end: code conversion, offset subtraction with saturation,
// and power-of-two block averaging with a shared decimation window.
module adc_frontend_nch_lane #(
    parameter int BITS = 14,
    parameter int AW   = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] i_adc,
    input  logic            i_inv,
    input  logic [BITS-1:0] i_off,
    input  logic            i_clr,
    input  logic            i_s1_vld,
    input  logic            i_s2_vld,
    input  logic            i_last,
    input  logic [2:0]      i_shift,
    output logic [BITS-1:0] o_avg,
    output logic            o_ovf
);
    logic [BITS-1:0]        r_s1, r_s2, r_avg;
    logic                   r_ovf;
    logic signed [AW-1:0]   r_acc;
    logic [BITS:0]          w_diff;
    logic                   w_sat;
    logic [BITS-1:0]        w_s2;
    logic signed [AW-1:0]   w_sum;

    assign w_diff = {r_s1[BITS-1], r_s1} - {i_off[BITS-1], i_off};
    assign w_sat  = w_diff[BITS] ^ w_diff[BITS-1];
    assign w_s2   = !w_sat        ? w_diff[BITS-1:0] :
                    w_diff[BITS]  ? {1'b1, {(BITS-1){1'b0}}} :
                                    {1'b0, {(BITS-1){1'b1}}};
    assign w_sum  = r_acc + AW'($signed(r_s2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_ovf <= 1'b0;
            r_acc <= '0;
            r_avg <= '0;
        end else begin
            // Offset binary to two's complement; inverted front end flips the magnitude bits
            r_s1 <= i_inv ? {i_adc[BITS-1], ~i_adc[BITS-2:0]}
                          : {~i_adc[BITS-1], i_adc[BITS-2:0]};
            r_s2 <= w_s2;
            if (w_sat && i_s1_vld) r_ovf <= 1'b1;
            else if (i_clr)        r_ovf <= 1'b0;
            if (i_s2_vld) begin
                if (i_last) begin
                    r_acc <= '0;
                    r_avg <= BITS'(w_sum >>> i_shift);
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign o_avg = r_avg;
    assign o_ovf = r_ovf;
endmodule

module adc_frontend_nch #(
    parameter int BITS         = 14,
    parameter int CH           = 2,
    parameter int MAX_DEC_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH*BITS-1:0] adc_i,
    input  logic [CH-1:0]      invert_en,
    input  logic [CH*BITS-1:0] offset_i,
    input  logic [2:0]         dec_log2,
    input  logic               clr_ovf,
    output logic [CH*BITS-1:0] adc_o,
    output logic               valid_o,
    output logic [CH-1:0]      ovf_o
);
    localparam int AW = BITS + MAX_DEC_LOG2;
    localparam int CW = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

    logic [1:0]    r_vld;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_dec;
    logic          r_valid;
    logic [2:0]    w_dec_in, w_shift;
    logic [CW:0]   w_n;
    logic          w_last;

    assign w_dec_in = (dec_log2 > 3'(MAX_DEC_LOG2)) ? 3'(MAX_DEC_LOG2) : dec_log2;
    // At window start the fresh dec_log2 applies immediately so N=1 works on the first sample
    assign w_shift  = (r_cnt == '0) ? w_dec_in : r_dec;
    assign w_n      = {{CW{1'b0}}, 1'b1} << w_shift;
    assign w_last   = ({1'b0, r_cnt} == (w_n - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= '0;
            r_cnt   <= '0;
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_vld <= {r_vld[0], 1'b1};
            if (r_vld[1]) begin
                if (r_cnt == '0) r_dec <= w_dec_in;
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                r_valid <= w_last;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o = r_valid;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        adc_frontend_nch_lane #(.BITS(BITS), .AW(AW)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_adc    (adc_i[g*BITS +: BITS]),
            .i_inv    (invert_en[g]),
            .i_off    (offset_i[g*BITS +: BITS]),
            .i_clr    (clr_ovf),
            .i_s1_vld (r_vld[0]),
            .i_s2_vld (r_vld[1]),
            .i_last   (w_last),
            .i_shift  (w_shift),
            .o_avg    (adc_o[g*BITS +: BITS]),
            .o_ovf    (ovf_o[g])
        );
    end
endmodule

// File: tb/tb_adc_frontend_nch.sv
// Directed bench for adc_frontend_nch (BITS=14, CH=2, MAX_DEC_LOG2=4).
module tb_adc_frontend_nch;
    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] adc_i;
    logic [1:0]  invert_en;
    logic [27:0] offset_i;
    logic [2:0]  dec_log2;
    logic        clr_ovf;
    logic [27:0] adc_o;
    logic        valid_o;
    logic [1:0]  ovf_o;
    int n_chk = 0;
    int n_pass = 0;

    adc_frontend_nch #(.BITS(14), .CH(2), .MAX_DEC_LOG2(4)) dut (
        .clk(clk), .rst(rst), .adc_i(adc_i), .invert_en(invert_en),
        .offset_i(offset_i), .dec_log2(dec_log2), .clr_ovf(clr_ovf),
        .adc_o(adc_o), .valid_o(valid_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raw code that a non-inverted front end converts to value v
    function automatic logic [13:0] raw(input int v);
        logic [13:0] t;
        t = 14'(v);
        return t ^ 14'h2000;
    endfunction

    task automatic apply(input int a0, input int a1);
        adc_i = {raw(a1), raw(a0)};
    endtask

    function automatic logic signed [31:0] och(input int c);
        return 32'($signed(adc_o[c*14 +: 14]));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    initial begin
        rst = 1'b0; adc_i = '0; invert_en = '0; offset_i = '0; dec_log2 = 3'd0; clr_ovf = 1'b0;
        #3;
        chk("rst_adc_o", 32'(adc_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        ticks(2);
        chk("rst_clk_adc_o", 32'(adc_o), 0);
        chk("rst_clk_valid", 32'(valid_o), 0);

        // dec=0 basic conversion, first valid on the 3rd edge
        rst = 1'b1;
        adc_i = {14'h2000, 14'h2000}; tick();
        chk("e1_valid", 32'(valid_o), 0);
        adc_i = {14'h3FFF, 14'h3FFF}; tick();
        chk("e2_valid", 32'(valid_o), 0);
        adc_i = {14'h0000, 14'h0000}; tick();
        chk("e3_valid", 32'(valid_o), 1);
        chk("mid_code", och(0), 0);
        adc_i = {14'h2000, 14'h2000}; tick();
        chk("max_code", och(0), 8191);
        chk("max_code_ch1", och(1), 8191);
        chk("e4_valid", 32'(valid_o), 1);
        tick();
        chk("min_code", och(0), -8192);
        chk("e5_valid", 32'(valid_o), 1);

        // ch0 inverted, ch1 normal
        invert_en = 2'b01;
        adc_i = {14'h0000, 14'h0000}; ticks(3);
        chk("inv_zero_ch0", och(0), 8191);
        chk("inv_zero_ch1", och(1), -8192);
        adc_i = {14'h3FFF, 14'h3FFF}; ticks(3);
        chk("inv_full_ch0", och(0), -8192);
        chk("inv_full_ch1", och(1), 8191);
        chk("no_ovf_yet", 32'(ovf_o), 0);
        invert_en = 2'b00;

        // saturation and sticky overflow
        offset_i = {14'h0000, 14'(-100)};
        adc_i = {14'h3FFF, 14'h3FFF}; ticks(3);
        chk("sat_ch0", och(0), 8191);
        chk("sat_ch1", och(1), 8191);
        chk("ovf_set", 32'(ovf_o), 1);
        adc_i = {14'h3FFF, 14'h2000}; ticks(3);
        chk("off_in_range", och(0), 100);
        chk("ovf_sticky", 32'(ovf_o), 1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf_o), 0);
        adc_i = {14'h3FFF, 14'h3FFF}; tick();
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_clr_vs_sat", 32'(ovf_o), 1);
        adc_i = {14'h2000, 14'h2000}; offset_i = '0; ticks(3);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_clr2", 32'(ovf_o), 0);

        // dec=2 windows, aligned by reset
        dec_log2 = 3'd2;
        rst = 1'b0; tick(); rst = 1'b1;
        apply(1, 8); tick();
        apply(2, 8); tick();
        apply(3, 8); tick();
        apply(6, 9); tick();
        apply(-1, -8192); tick();
        chk("d2_e5_valid", 32'(valid_o), 0);
        tick();
        chk("d2_avg_ch0", och(0), 3);
        chk("d2_avg_ch1", och(1), 8);
        chk("d2_e6_valid", 32'(valid_o), 1);
        apply(-1, -8192); tick();
        chk("d2_e7_valid", 32'(valid_o), 0);
        chk("d2_hold", och(0), 3);
        apply(-2, -8192); tick();
        apply(5, 5); tick();
        chk("d2_e9_valid", 32'(valid_o), 0);
        tick();
        chk("d2_floor_ch0", och(0), -2);
        chk("d2_min_ch1", och(1), -8192);
        chk("d2_e10_valid", 32'(valid_o), 1);
        ticks(2);

        // reset mid-window discards the partial sum
        rst = 1'b0; #1;
        chk("mid_rst_adc_o", 32'(adc_o), 0);
        chk("mid_rst_valid", 32'(valid_o), 0);
        tick(); rst = 1'b1;
        apply(4, -3); tick();
        apply(4, -3); tick();
        apply(4, -3); tick();
        apply(4, -2); tick();
        apply(10, 10); tick();
        chk("rr_e5_valid", 32'(valid_o), 0);
        apply(20, 20); tick();
        chk("rr_avg_ch0", och(0), 4);
        chk("rr_avg_ch1", och(1), -3);
        chk("rr_e6_valid", 32'(valid_o), 1);

        // dec 2 -> 0 mid-window: current window completes first
        apply(30, 30); tick();
        dec_log2 = 3'd0;
        apply(40, 40); tick();
        chk("chg_e8_valid", 32'(valid_o), 0);
        apply(7, 7); tick();
        chk("chg_e9_valid", 32'(valid_o), 0);
        apply(-5, -5); tick();
        chk("chg_last_window", och(0), 25);
        chk("chg_e10_valid", 32'(valid_o), 1);
        tick();
        chk("chg_per_cycle0", och(0), 7);
        chk("chg_e11_valid", 32'(valid_o), 1);
        tick();
        chk("chg_per_cycle1", och(1), -5);
        chk("chg_e12_valid", 32'(valid_o), 1);

        // dec=7 clamps to 16-sample windows
        dec_log2 = 3'd7;
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply((i == 15) ? 116 : 100, 100);
            tick();
        end
        apply(100, 100); tick();
        chk("clamp_e17_valid", 32'(valid_o), 0);
        tick();
        chk("clamp_e18_valid", 32'(valid_o), 1);
        chk("clamp_avg_ch0", och(0), 101);
        chk("clamp_avg_ch1", och(1), 100);
        ticks(15);
        chk("clamp_e33_valid", 32'(valid_o), 0);
        tick();
        chk("clamp_e34_valid", 32'(valid_o), 1);
        chk("clamp_avg2_ch0", och(0), 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adc_frontend_nch.md
ADC_FRONTEND_NCH -- requirements
Module: adc_frontend_nch

Interface
REQ-001 Parameter BITS, default 14, ADC sample width and output width per channel.
REQ-002 Parameter CH, default 2, number of independent ADC channels, valid range 1..8.
REQ-003 Parameter MAX_DEC_LOG2, default 4, largest supported log2 decimation factor, valid range 0..7.
REQ-004 clk  input  1  sample clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 adc_i  input  CH*BITS  raw offset-binary ADC codes; channel c occupies bits [c*BITS +: BITS].
REQ-007 invert_en  input  CH  per-channel polarity; 1 = inverted front end (minimum code = +full scale).
REQ-008 offset_i  input  CH*BITS  per-channel signed two's-complement offset to subtract.
REQ-009 dec_log2  input  3  log2 of the averaging/decimation factor N; values above MAX_DEC_LOG2 are clamped to MAX_DEC_LOG2.
REQ-010 clr_ovf  input  1  synchronous clear of all sticky overflow flags.
REQ-011 adc_o  output  CH*BITS  signed two's-complement averaged samples, same channel packing as adc_i.
REQ-012 valid_o  output  1  one-cycle strobe; adc_o is new and valid on this cycle.
REQ-013 ovf_o  output  CH  per-channel sticky saturation flag.

Function
REQ-014 Stage 1 (registered) SHALL convert each channel: invert_en=0 -> {~msb, lsbs}; invert_en=1 -> {msb, ~lsbs}.
REQ-015 Stage 2 (registered) SHALL compute stage1 - offset at BITS+1 bits and saturate to [-2^(BITS-1), 2^(BITS-1)-1].
REQ-016 Any saturation event in stage 2 SHALL set ovf_o[c] on the same edge that registers the stage-2 result.
REQ-017 ovf_o[c] SHALL hold until clr_ovf=1 at a rising edge; a saturation event on the same edge as clr_ovf SHALL leave the flag set.
REQ-018 Each stage SHALL carry a valid bit; after reset, stages become valid in order; the accumulator SHALL ignore stage-2 data while its valid bit is 0.
REQ-019 Stage 3 SHALL accumulate, per channel, N = 2^dec_log2 consecutive valid stage-2 samples in a signed accumulator of BITS+MAX_DEC_LOG2 bits, with no overflow possible.
REQ-020 A shared window counter SHALL count 0..N-1 and wrap to 0 after N-1.
REQ-021 On the sample at count N-1, adc_o SHALL be loaded with (accumulator + sample) arithmetically shifted right by dec_log2 (floor toward minus infinity), valid_o SHALL be 1 for exactly that cycle, and the accumulator SHALL restart from 0.
REQ-022 dec_log2 SHALL be latched when the counter is 0 at window start; changes mid-window SHALL take effect at the next window start only.
REQ-023 With dec_log2=0, adc_o SHALL update and valid_o SHALL be 1 on every cycle once the pipeline is full; latency from adc_i to adc_o is 3 clk cycles.
REQ-024 With N>1, the result SHALL appear 3 cycles after the last sample of its window is applied at adc_i; valid_o SHALL then repeat every N cycles.
REQ-025 adc_o SHALL hold its last value between valid_o strobes.
REQ-026 Channels SHALL be fully independent in data path and flags and SHALL share only the window counter and valid_o.

Reset
REQ-027 While rst=0: adc_o=0, valid_o=0, ovf_o=0, all stage registers, valid bits, accumulators, window counter and latched dec_log2 SHALL be 0, regardless of clk.
REQ-028 Reset asserted mid-window SHALL discard the partial window; after release, the first window starts with the first valid stage-2 sample.
REQ-029 After rst release with dec_log2=0, the first valid_o SHALL occur on the 3rd rising edge.

Verification
REQ-030 BITS=14, dec=0, offset=0, invert=0: adc_i 14'h2000/14'h3FFF/14'h0000 -> adc_o 0/+8191/-8192, 3 cycles later, valid_o held 1.
REQ-031 invert=1: adc_i 14'h0000 -> +8191; 14'h3FFF -> -8192; ch0 inverted and ch1 normal with identical input give opposite-sign results.
REQ-032 invert=0, adc_i 14'h3FFF, offset -100 -> adc_o +8191 and ovf_o[0]=1; pulse clr_ovf with input in range -> 0; clr_ovf on the same edge as a new saturation -> stays 1.
REQ-033 dec=2, converted samples 1,2,3,6 -> adc_o 3, one valid_o per 4 cycles; samples -1,-1,-1,-2 -> adc_o -2.
REQ-034 dec=2, rst pulsed low after 2 window samples -> all outputs 0 immediately; after release, the next 4 samples 4,4,4,4 -> adc_o 4.
REQ-035 dec_log2 changed 2->0 mid-window -> the current 4-sample window completes, then per-cycle output follows; dec_log2=7 with MAX_DEC_LOG2=4 behaves as 4.
